hazard_unit: RTL

Pipeline hazard controller for the five-stage core. It tracks destination-register metadata for the instructions in the Execute, Memory and Writeback stages in its own shadow registers. From these it produces the forwarding selects consumed by the Execute stage (`00` none, `01` from Memory, `10` from Writeback), a Writeback-to-Decode register-file bypass, load-use stalls, and branch flushes. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_unit_if.sv | 39 +++
 rtl/hazard_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// Decode-side hazard request and hazard-control response bundle between the core pipeline and hazard_unit.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic             uses_rs1_D;
    logic             uses_rs2_D;
    logic [4:0]       rd_D;
    logic             reg_write_D;
    logic             mem_read_D;
    logic             pc_src_E;
    logic             ext_stall;

    logic [1:0]       forward_A_E;
    logic [1:0]       forward_B_E;
    logic             forward_A_D;
    logic             forward_B_D;
    logic             stall_F;
    logic             stall_D;
    logic             flush_D;
    logic             flush_E;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_D, reg_write_D, mem_read_D,
        output pc_src_E, ext_stall,
        input  forward_A_E, forward_B_E, forward_A_D, forward_B_D,
        input  stall_F, stall_D, flush_D, flush_E, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_D, reg_write_D, mem_read_D,
        input  pc_src_E, ext_stall,
        output forward_A_E, forward_B_E, forward_A_D, forward_B_D,
        output stall_F, stall_D, flush_D, flush_E, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage hazard controller: forwarding selects, W->D bypass, load-use stall, branch flush, perf counters.
// All controls are combinational in the same cycle; ext_stall freezes the shadow pipeline.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ex_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } mem_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
    } wb_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ex_t              ex_q, ex_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             lw_stall;
    logic             stall;
    logic             flush_e;
    logic             flush_d;

    // Memory beats Writeback: the instruction in M is younger, so its value is newer.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input mem_t m, input wb_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.rw && !m.mr && (m.rd != 5'd0) && (m.rd == rs)) begin
            sel = 2'b01;
        end else if (w.rw && (w.rd != 5'd0) && (w.rd == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        lw_stall = ex_q.mr && ex_q.rw && (ex_q.rd != 5'd0) &&
                   ((hz.uses_rs1_D && (hz.rs1_D == ex_q.rd)) ||
                    (hz.uses_rs2_D && (hz.rs2_D == ex_q.rd))) &&
                   !hz.pc_src_E;
        stall    = lw_stall || hz.ext_stall;
        flush_d  = hz.pc_src_E && !hz.ext_stall;
        flush_e  = (lw_stall || hz.pc_src_E) && !hz.ext_stall;
    end

    assign hz.forward_A_E = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign hz.forward_B_E = fwd_sel(ex_q.rs2, mem_q, wb_q);
    assign hz.forward_A_D = wb_q.rw && (wb_q.rd != 5'd0) && (wb_q.rd == hz.rs1_D);
    assign hz.forward_B_D = wb_q.rw && (wb_q.rd != 5'd0) && (wb_q.rd == hz.rs2_D);
    assign hz.stall_F     = stall;
    assign hz.stall_D     = stall;
    assign hz.flush_D     = flush_d;
    assign hz.flush_E     = flush_e;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

    // A load-use stall inserts a bubble into E while M and W keep draining.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!hz.ext_stall) begin
            if (flush_e) begin
                ex_d = '0;
            end else begin
                ex_d.rs1 = hz.rs1_D;
                ex_d.rs2 = hz.rs2_D;
                ex_d.rd  = hz.rd_D;
                ex_d.rw  = hz.reg_write_D;
                ex_d.mr  = hz.mem_read_D;
            end
            mem_d.rd = ex_q.rd;
            mem_d.rw = ex_q.rw;
            mem_d.mr = ex_q.mr;
            wb_d.rd  = mem_q.rd;
            wb_d.rw  = mem_q.rw;
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_e && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
